// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings (also decoded by control_unit), the FSM state type and small
// op-decode helpers.
package muldiv_pkg;

  // Operation select encodings; bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // Sequencer states of the unit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for DIV and DIVU.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // True for MULT and DIV, which work on two's-complement operands.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with its own HI/LO registers.
// One bit is processed per cycle on magnitudes, signs are applied in a single
// FIX cycle afterwards. Divide-by-zero skips the iteration entirely and leaves
// HI/LO untouched.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH+1:0] div_trial;
  logic [AW-1:0]    div_next;
  logic             res_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Input conditioning: sign bits and unsigned magnitudes of the operands.
  // Negating the most-negative value yields 2^(WIDTH-1), exact as unsigned.
  always_comb begin
    in_neg_a = op_is_signed(op) & a[WIDTH-1];
    in_neg_b = op_is_signed(op) & b[WIDTH-1];
    mag_a    = in_neg_a ? -a : a;
    mag_b    = in_neg_b ? -b : b;
  end

  // One iteration step for both algorithms on the shared accumulator.
  // Multiply: add multiplicand to the upper half when the LSB is set, shift right.
  // Divide: shift left, trial-subtract the divisor, keep it only if no borrow.
  always_comb begin
    mul_sum   = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
    div_next  = div_trial[WIDTH+1] ? {acc_q[2*WIDTH-1:0], 1'b0}
                                   : {div_trial[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up of the finished magnitude results.
  // Quotient and product flip on differing signs; remainder follows the dividend.
  always_comb begin
    res_neg  = sign_a_q ^ sign_b_q;
    prod_fix = res_neg ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quot_fix = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer: next-state and next-output computation for every register.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (op_is_div(op) && (b == '0)) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d  = ST_CALC;
            op_d     = op;
            sign_a_d = in_neg_a;
            sign_b_d = in_neg_b;
            cnt_d    = CW'(WIDTH);
            if (op_is_div(op)) begin
              acc_d  = {{(WIDTH + 1){1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {{(WIDTH + 1){1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end
      ST_CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
